// File: rtl/imem_fetch_frontend.sv
// imem_fetch_frontend
//   Instruction fetch initiator. Every request reserves a reorder slot first,
//   so responses (which carry no ready and may return out of order) always
//   have a place to land. Instructions leave in program order through a
//   ready/valid port. A redirect squashes everything in flight. Squashed
//   slots still wait for their response and are then retired silently.
//
// Ports
//   clock, reset                      clock; synchronous active-high reset
//   fetch_en                          permits new requests
//   redirect_valid, redirect_pc       squash in-flight fetches, restart at redirect_pc
//   imem_req_valid/_bits_tag/_bits_pc request to instruction memory (tag = slot index)
//   imem_resp_valid/_bits_tag/_bits_inst  response from memory (no backpressure)
//   out_valid, out_ready              in-order instruction handoff to decode
//   out_bits_pc, out_bits_inst        instruction and its PC (zero while !out_valid)
//   resp_error                        sticky: bad tag or response to a non-pending slot
module imem_fetch_frontend #(
  parameter int ARCH_LEN      = 32,
  parameter int INST_BITS     = 64,
  parameter int IMEM_TAG_BITS = 64,
  parameter int MAX_INFLIGHT  = 4,
  parameter int INST_BYTES    = 8,
  parameter logic [ARCH_LEN-1:0] START_PC = 32'h8000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ARCH_LEN-1:0]      redirect_pc,
  output logic                     imem_req_valid,
  output logic [IMEM_TAG_BITS-1:0] imem_req_bits_tag,
  output logic [ARCH_LEN-1:0]      imem_req_bits_pc,
  input  logic                     imem_resp_valid,
  input  logic [IMEM_TAG_BITS-1:0] imem_resp_bits_tag,
  input  logic [INST_BITS-1:0]     imem_resp_bits_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ARCH_LEN-1:0]      out_bits_pc,
  output logic [INST_BITS-1:0]     out_bits_inst,
  output logic                     resp_error
);

  localparam int IDX_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_state_t;

  // Slot control state (reset) and slot payload (not reset).
  slot_state_t          slot_state  [MAX_INFLIGHT];
  logic                 slot_squash [MAX_INFLIGHT];
  logic [ARCH_LEN-1:0]  slot_pc     [MAX_INFLIGHT];
  logic [INST_BITS-1:0] slot_inst   [MAX_INFLIGHT];

  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [ARCH_LEN-1:0] fetch_pc;
  logic                resp_error_q;

  logic             issue;
  logic             head_done;
  logic             out_valid_c;
  logic             pop_live;
  logic             pop_silent;
  logic             pop;
  logic [IDX_W-1:0] resp_idx;
  logic             resp_tag_in_range;
  logic             resp_ok;
  logic             resp_bad;

  always_comb begin
    head_done   = (slot_state[head] == SLOT_DONE);
    // Issue looks only at the registered count: a pop this cycle does not
    // free a slot for an issue until the next cycle.
    issue       = !reset && fetch_en && !redirect_valid && (count < CNT_W'(MAX_INFLIGHT));
    out_valid_c = !reset && !redirect_valid && head_done && !slot_squash[head];
    pop_live    = out_valid_c && out_ready;
    // Squashed results retire without being shown to decode.
    pop_silent  = !reset && head_done && slot_squash[head];
    pop         = pop_live || pop_silent;

    resp_idx          = imem_resp_bits_tag[IDX_W-1:0];
    resp_tag_in_range = ((imem_resp_bits_tag >> IDX_W) == '0);
    resp_ok  = imem_resp_valid && resp_tag_in_range && (slot_state[resp_idx] == SLOT_PENDING);
    resp_bad = imem_resp_valid && !resp_ok;
  end

  // Control: slot states, squash bits, pointers, fetch PC, error flag.
  // Issue targets a FREE slot, a good response a PENDING one and a pop a DONE
  // one, so the three writes below never hit the same slot in one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fetch_pc     <= START_PC;
      resp_error_q <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        slot_state[i]  <= SLOT_FREE;
        slot_squash[i] <= 1'b0;
      end
    end else begin
      if (redirect_valid) begin
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
          if (slot_state[i] != SLOT_FREE) slot_squash[i] <= 1'b1;
        end
        fetch_pc <= redirect_pc;
      end
      if (issue) begin
        slot_state[tail]  <= SLOT_PENDING;
        slot_squash[tail] <= 1'b0;
        tail              <= tail + IDX_W'(1);
        fetch_pc          <= fetch_pc + ARCH_LEN'(INST_BYTES);
      end
      if (resp_ok) slot_state[resp_idx] <= SLOT_DONE;
      if (resp_bad) resp_error_q <= 1'b1;
      if (pop) begin
        slot_state[head] <= SLOT_FREE;
        head             <= head + IDX_W'(1);
      end
      count <= count + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  // Payload capture.
  always_ff @(posedge clock) begin
    if (issue) slot_pc[tail] <= fetch_pc;
    if (resp_ok) slot_inst[resp_idx] <= imem_resp_bits_inst;
  end

  assign imem_req_valid    = issue;
  assign imem_req_bits_tag = IMEM_TAG_BITS'(tail);
  assign imem_req_bits_pc  = fetch_pc;
  assign out_valid         = out_valid_c;
  assign out_bits_pc       = out_valid_c ? slot_pc[head]   : '0;
  assign out_bits_inst     = out_valid_c ? slot_inst[head] : '0;
  assign resp_error        = resp_error_q;

endmodule

// File: tb/tb_imem_fetch_frontend.sv
module tb_imem_fetch_frontend;

  localparam int          MAXI       = 4;
  localparam int          INST_BYTES = 8;
  localparam logic [31:0] START_PC   = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_bits_tag;
  logic [31:0] imem_req_bits_pc;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_bits_tag = '0;
  logic [63:0] imem_resp_bits_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_bits_pc;
  logic [63:0] out_bits_inst;
  logic        resp_error;

  imem_fetch_frontend dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .imem_req_valid      (imem_req_valid),
    .imem_req_bits_tag   (imem_req_bits_tag),
    .imem_req_bits_pc    (imem_req_bits_pc),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_bits_tag  (imem_resp_bits_tag),
    .imem_resp_bits_inst (imem_resp_bits_inst),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_bits_pc         (out_bits_pc),
    .out_bits_inst       (out_bits_inst),
    .resp_error          (resp_error)
  );

  always #5 clock = ~clock;

  // Memory model entry: an outstanding request and the cycle it may answer.
  typedef struct {
    logic [63:0] tag;
    logic [31:0] pc;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];      // PCs still owed to decode, in program order
  logic [31:0] req_pc_log[$];
  logic [31:0] model_pc;
  int          model_tag;
  int          cyc;
  int          req_count;
  int          out_count;
  int          first_req_cyc;
  int          first_out_cyc;
  logic [31:0] first_out_pc;
  logic        last_req;
  logic        last_out;
  bit          mem_auto;
  bit          mem_ooo;
  int          lat_min;
  int          lat_max;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [63:0] inst_of(input logic [31:0] pc);
    return {pc ^ 32'hC0DE_F00D, ~pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic run_cycle();
    int ready_idx[$];
    int k;
    if (mem_auto) begin
      imem_resp_valid     = 1'b0;
      imem_resp_bits_tag  = '0;
      imem_resp_bits_inst = '0;
      if (!reset) begin
        for (int i = 0; i < mem_q.size(); i++)
          if (mem_q[i].due <= cyc) ready_idx.push_back(i);
        if (ready_idx.size() > 0) begin
          k = mem_ooo ? ready_idx[$urandom_range(ready_idx.size() - 1)] : ready_idx[0];
          imem_resp_valid     = 1'b1;
          imem_resp_bits_tag  = mem_q[k].tag;
          imem_resp_bits_inst = inst_of(mem_q[k].pc);
          mem_q.delete(k);
        end
      end
    end
    #1;
    last_req = imem_req_valid;
    last_out = out_valid;
    if (!reset) begin
      if (redirect_valid || !fetch_en) chk("req_blocked", 64'(imem_req_valid), 64'd0);
      if (redirect_valid) chk("out_blocked_redirect", 64'(out_valid), 64'd0);
      if (imem_req_valid) begin
        chk("req_pc", 64'(imem_req_bits_pc), 64'(model_pc));
        chk("req_tag", imem_req_bits_tag, 64'(model_tag));
        if (first_req_cyc < 0) first_req_cyc = cyc;
        req_count++;
        req_pc_log.push_back(imem_req_bits_pc);
        exp_q.push_back(model_pc);
        if (mem_auto)
          mem_q.push_back('{tag: 64'(model_tag), pc: model_pc,
                            due: cyc + int'($urandom_range(lat_max, lat_min))});
        model_pc  = model_pc + 32'(INST_BYTES);
        model_tag = (model_tag + 1) % MAXI;
      end
      if (out_valid) begin
        if (first_out_cyc < 0) begin
          first_out_cyc = cyc;
          first_out_pc  = out_bits_pc;
        end
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 64'(out_valid), 64'd0);
        end else begin
          chk("out_pc", 64'(out_bits_pc), 64'(exp_q[0]));
          chk("out_inst", out_bits_inst, inst_of(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_count++;
          end
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic respond(input logic [63:0] tag, input logic [63:0] inst);
    imem_resp_valid     = 1'b1;
    imem_resp_bits_tag  = tag;
    imem_resp_bits_inst = inst;
    run_cycle();
    imem_resp_valid     = 1'b0;
    imem_resp_bits_tag  = '0;
    imem_resp_bits_inst = '0;
  endtask

  // Holds reset across one edge, checks the reset outputs, then releases.
  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_bits_tag = '0;
    imem_resp_bits_inst = '0;
    run_cycle();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_tag", imem_req_bits_tag, 64'd0);
    chk("rst_req_pc", 64'(imem_req_bits_pc), 64'(START_PC));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_bits_pc), 64'd0);
    chk("rst_out_inst", out_bits_inst, 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    mem_q.delete();
    exp_q.delete();
    req_pc_log.delete();
    model_pc = START_PC;
    model_tag = 0;
    cyc = 0;
    req_count = 0;
    out_count = 0;
    first_req_cyc = -1;
    first_out_cyc = -1;
    first_out_pc = '0;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_auto = 1'b1;
    mem_ooo  = 1'b0;
    lat_min  = 1;
    lat_max  = 1;

    // Sequential fetch, 1-cycle memory.
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (12) run_cycle();
    chk("seq_first_req_cycle", 64'(first_req_cyc), 64'd0);
    chk("seq_first_out_cycle", 64'(first_out_cyc), 64'd2);
    chk("seq_req_count", 64'(req_count), 64'd12);
    chk("seq_out_count", 64'(out_count), 64'd10);

    // Full stall, then one pop re-enables issue a cycle later.
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    repeat (8) run_cycle();
    chk("stall_req_count", 64'(req_count), 64'd4);
    chk("stall_req_low", 64'(last_req), 64'd0);
    out_ready = 1'b1;
    run_cycle();
    chk("stall_pop_valid", 64'(last_out), 64'd1);
    chk("stall_no_req_on_pop", 64'(last_req), 64'd0);
    out_ready = 1'b0;
    run_cycle();
    chk("stall_reissue", 64'(last_req), 64'd1);

    // Out-of-order responses 2,0,3,1.
    do_reset();
    mem_auto = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (4) run_cycle();
    fetch_en = 1'b0;
    chk("ooo_req_count", 64'(req_count), 64'd4);
    respond(64'd2, inst_of(START_PC + 32'd16));
    chk("ooo_wait_after_t2", 64'(last_out), 64'd0);
    respond(64'd0, inst_of(START_PC));
    chk("ooo_wait_during_t0", 64'(last_out), 64'd0);
    respond(64'd3, inst_of(START_PC + 32'd24));
    chk("ooo_out_after_t0", 64'(last_out), 64'd1);
    respond(64'd1, inst_of(START_PC + 32'd8));
    repeat (4) run_cycle();
    chk("ooo_out_count", 64'(out_count), 64'd4);

    // Redirect with three pending slots.
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (3) run_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    run_cycle();
    chk("redir_no_req", 64'(last_req), 64'd0);
    redirect_valid = 1'b0;
    run_cycle();
    fetch_en = 1'b0;
    chk("redir_new_req_pc", 64'(req_pc_log[req_pc_log.size() - 1]), 64'h1000);
    respond(64'd1, inst_of(START_PC + 32'd8));
    respond(64'd0, inst_of(START_PC));
    respond(64'd2, inst_of(START_PC + 32'd16));
    respond(64'd3, inst_of(32'h0000_1000));
    repeat (3) run_cycle();
    chk("redir_out_count", 64'(out_count), 64'd1);
    chk("redir_first_out_pc", 64'(first_out_pc), 64'h1000);

    // Out-of-range tag aliasing a pending slot, then unknown tag 5.
    do_reset();
    fetch_en = 1'b1;
    run_cycle();
    fetch_en = 1'b0;
    respond(64'd4, 64'hDEAD_0004);
    chk("bogus_tag4_err", 64'(resp_error), 64'd1);
    run_cycle();
    chk("bogus_slot_still_pending", 64'(last_out), 64'd0);
    respond(64'd0, inst_of(START_PC));
    respond(64'd5, 64'hDEAD_0005);
    chk("bogus_head_pc", 64'(out_bits_pc), 64'(START_PC));
    chk("bogus_head_inst", out_bits_inst, inst_of(START_PC));
    out_ready = 1'b1;
    repeat (2) run_cycle();
    chk("bogus_out_count", 64'(out_count), 64'd1);
    chk("bogus_sticky", 64'(resp_error), 64'd1);

    // Duplicate response for a DONE slot.
    do_reset();
    fetch_en = 1'b1;
    run_cycle();
    fetch_en = 1'b0;
    respond(64'd0, inst_of(START_PC));
    run_cycle();
    chk("dup_no_err_yet", 64'(resp_error), 64'd0);
    respond(64'd0, 64'hBAD0_BAD0_BAD0_BAD0);
    chk("dup_err", 64'(resp_error), 64'd1);
    out_ready = 1'b1;
    run_cycle();
    chk("dup_out_count", 64'(out_count), 64'd1);
    chk("dup_sticky", 64'(resp_error), 64'd1);

    // PC wrap, mid-flight reset, late response.
    do_reset();
    mem_auto = 1'b1;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    run_cycle();
    redirect_valid = 1'b0;
    repeat (3) run_cycle();
    chk("wrap_pc0", 64'(req_pc_log[0]), 64'hFFFF_FFF8);
    chk("wrap_pc1", 64'(req_pc_log[1]), 64'h0);
    do_reset();
    mem_auto = 1'b0;
    respond(64'd1, 64'h1234);
    chk("late_resp_err", 64'(resp_error), 64'd1);

    // Randomised traffic against the reference model.
    do_reset();
    mem_auto = 1'b1;
    mem_ooo = 1'b1;
    lat_min = 1;
    lat_max = 6;
    for (int i = 0; i < 3000; i++) begin
      fetch_en = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(29) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFF8);
      run_cycle();
    end
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 300 && (mem_q.size() > 0 || exp_q.size() > 0); n++) run_cycle();
    chk("rand_drained", 64'(mem_q.size() + exp_q.size()), 64'd0);
    chk("rand_no_err", 64'(resp_error), 64'd0);
    chk("rand_outputs_seen", 64'(out_count > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
